alu_seq: RTL

ALU_SEQ -- requirements
Module: alu_seq

---
 rtl/alu_seq.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - request/response sequencer driving an external 32-bit ALU
// 64-bit ADD/SUB (ops 8/9) and the EXEC_HI state exist only when ALU_SEQ_WIDE_EN is defined.
module alu_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [63:0] req_a,
  input  logic [63:0] req_b,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_s,
  output logic        rsp_z,
  output logic        rsp_c,
  output logic        rsp_err,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic        alu_cin,
  output logic [2:0]  alu_ops,
  input  logic [31:0] alu_s,
  input  logic        alu_zero,
  input  logic        alu_cout
);

  localparam logic [3:0] OP_ADD   = 4'd0;
  localparam logic [3:0] OP_SUB   = 4'd1;
  localparam logic [3:0] OP_ADD64 = 4'd8;
  localparam logic [3:0] OP_SUB64 = 4'd9;
  localparam logic [3:0] OP_ADC   = 4'd10;

`ifdef ALU_SEQ_WIDE_EN
  localparam logic P_WIDE = 1'b1;
`else
  localparam logic P_WIDE = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_EXEC_LO = 2'd1,
    S_DONE    = 2'd2
`ifdef ALU_SEQ_WIDE_EN
    , S_EXEC_HI = 2'd3
`endif
  } state_t;

  function automatic logic f_illegal(input logic [3:0] op);
    return (op > OP_ADC) || (((op == OP_ADD64) || (op == OP_SUB64)) && !P_WIDE);
  endfunction

  function automatic logic f_wide(input logic [3:0] op);
    return ((op == OP_ADD64) || (op == OP_SUB64)) && P_WIDE;
  endfunction

  state_t      r_state;
  logic [3:0]  r_op;
  logic        r_req_ready;
  logic        r_rsp_valid;
  logic [31:0] r_rsp_lo;
  logic        r_rsp_z;
  logic        r_rsp_c;
  logic        r_rsp_err;
  logic        r_cflag;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic        r_alu_cin;
  logic [2:0]  r_alu_ops;

  logic        w_req_ill;
  logic        w_ill;
  logic        w_carry;

  assign w_req_ill = f_illegal(req_op);
  assign w_ill     = f_illegal(r_op);
  assign w_carry   = (r_op == OP_ADD) || (r_op == OP_SUB) || (r_op == OP_ADC);

`ifdef ALU_SEQ_WIDE_EN
  logic [31:0] r_a_hi;
  logic [31:0] r_b_hi;
  logic [31:0] r_rsp_hi;
  logic        w_hi_c;

  // SUB64 reports borrow, the complement of the adder's final carry
  assign w_hi_c = (r_op == OP_SUB64) ? ~alu_cout : alu_cout;
  assign rsp_s  = {r_rsp_hi, r_rsp_lo};
`else
  logic w_unused_hi;
  assign w_unused_hi = ^{req_a[63:32], req_b[63:32]};
  assign rsp_s       = {32'd0, r_rsp_lo};
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_op        <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_lo    <= 32'd0;
      r_rsp_z     <= 1'b0;
      r_rsp_c     <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_cflag     <= 1'b0;
      r_alu_a     <= 32'd0;
      r_alu_b     <= 32'd0;
      r_alu_cin   <= 1'b0;
      r_alu_ops   <= 3'd0;
`ifdef ALU_SEQ_WIDE_EN
      r_a_hi      <= 32'd0;
      r_b_hi      <= 32'd0;
      r_rsp_hi    <= 32'd0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_op        <= req_op;
            r_req_ready <= 1'b0;
            r_state     <= S_EXEC_LO;
`ifdef ALU_SEQ_WIDE_EN
            r_a_hi <= req_a[63:32];
            r_b_hi <= (req_op == OP_SUB64) ? ~req_b[63:32] : req_b[63:32];
`endif
            if (!w_req_ill) begin
              r_alu_a   <= req_a[31:0];
              // ops 8-10 all use the adder; SUB64 is A + ~B + 1
              r_alu_ops <= req_op[3] ? 3'b000 : req_op[2:0];
              if (req_op == OP_SUB64) begin
                r_alu_b   <= ~req_b[31:0];
                r_alu_cin <= 1'b1;
              end else begin
                r_alu_b   <= req_b[31:0];
                r_alu_cin <= (req_op == OP_ADC) ? r_cflag : 1'b0;
              end
            end
          end
        end
        S_EXEC_LO: begin
          r_alu_a   <= 32'd0;
          r_alu_b   <= 32'd0;
          r_alu_cin <= 1'b0;
          r_alu_ops <= 3'd0;
          if (w_ill) begin
            r_rsp_lo    <= 32'd0;
            r_rsp_z     <= 1'b0;
            r_rsp_c     <= 1'b0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
`ifdef ALU_SEQ_WIDE_EN
            r_rsp_hi    <= 32'd0;
          end else if (f_wide(r_op)) begin
            r_rsp_lo  <= alu_s;
            r_rsp_z   <= alu_zero;
            r_alu_a   <= r_a_hi;
            r_alu_b   <= r_b_hi;
            r_alu_cin <= alu_cout;
            r_state   <= S_EXEC_HI;
`endif
          end else begin
            r_rsp_lo    <= alu_s;
            r_rsp_z     <= alu_zero;
            r_rsp_c     <= w_carry & alu_cout;
            r_rsp_err   <= 1'b0;
            r_rsp_valid <= 1'b1;
            r_state     <= S_DONE;
            if (w_carry) r_cflag <= alu_cout;
`ifdef ALU_SEQ_WIDE_EN
            r_rsp_hi    <= 32'd0;
`endif
          end
        end
`ifdef ALU_SEQ_WIDE_EN
        S_EXEC_HI: begin
          r_rsp_hi    <= alu_s;
          r_rsp_z     <= r_rsp_z & alu_zero;
          r_rsp_c     <= w_hi_c;
          r_cflag     <= w_hi_c;
          r_rsp_err   <= 1'b0;
          r_rsp_valid <= 1'b1;
          r_alu_a     <= 32'd0;
          r_alu_b     <= 32'd0;
          r_alu_cin   <= 1'b0;
          r_alu_ops   <= 3'd0;
          r_state     <= S_DONE;
        end
`endif
        S_DONE: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_req_ready <= 1'b1;
            r_state     <= S_IDLE;
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
          r_rsp_valid <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = r_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_z     = r_rsp_z;
  assign rsp_c     = r_rsp_c;
  assign rsp_err   = r_rsp_err;
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_cin   = r_alu_cin;
  assign alu_ops   = r_alu_ops;

endmodule
